// File: rtl/dp_control_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dp_control_sequencer_if                                         |
// | Brief    : Control bundle between dp_control_sequencer and DataPathV5.     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface dp_control_sequencer_if #(
    parameter int STATE_W = 5
);
    logic [31:0]        IR;
    logic               MFC;
    logic               COND;
    logic               IRE, MDRE, MARE, PCE, nPCE, RFE;
    logic               ClrPC, nPCClr, IRClr;
    logic               MFA, ALUE, nPC_ADD, BAUX, ALU_SEL, AOP_SEL, DISP_SEL;
    logic [1:0]         nPC_SEL, MAR_SEL, MDR_SEL, CIN_SEL, RC_SEL;
    logic               TRAP_REQ;
    logic [STATE_W-1:0] STATE;

    modport master (
        input  IR, MFC, COND,
        output IRE, MDRE, MARE, PCE, nPCE, RFE, ClrPC, nPCClr, IRClr,
               MFA, ALUE, nPC_ADD, BAUX, ALU_SEL, AOP_SEL, DISP_SEL,
               nPC_SEL, MAR_SEL, MDR_SEL, CIN_SEL, RC_SEL, TRAP_REQ, STATE
    );

    modport slave (
        output IR, MFC, COND,
        input  IRE, MDRE, MARE, PCE, nPCE, RFE, ClrPC, nPCClr, IRClr,
               MFA, ALUE, nPC_ADD, BAUX, ALU_SEL, AOP_SEL, DISP_SEL,
               nPC_SEL, MAR_SEL, MDR_SEL, CIN_SEL, RC_SEL, TRAP_REQ, STATE
    );
endinterface
`default_nettype wire

// File: rtl/dp_control_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dp_control_sequencer                                            |
// | Brief    : Hardwired Moore sequencer for SPARC DataPathV5 (reset, fetch,   |
// |            decode, ALU, nPC update, Bicc). MFC_TIMEOUT_EN adds fetch trap. |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module dp_control_sequencer #(
    parameter int MFC_TIMEOUT = 15,
    parameter int STATE_W     = 5
) (
    input wire Clk,
    input wire Clr,
    dp_control_sequencer_if.master ctl
);

    localparam logic [STATE_W-1:0] c_RST0   = STATE_W'(0);
    localparam logic [STATE_W-1:0] c_RST1   = STATE_W'(1);
    localparam logic [STATE_W-1:0] c_FETCH1 = STATE_W'(2);
    localparam logic [STATE_W-1:0] c_FETCH2 = STATE_W'(3);
    localparam logic [STATE_W-1:0] c_FETCH3 = STATE_W'(4);
    localparam logic [STATE_W-1:0] c_DECODE = STATE_W'(5);
    localparam logic [STATE_W-1:0] c_ALU1   = STATE_W'(6);
    localparam logic [STATE_W-1:0] c_PCUPD1 = STATE_W'(7);
    localparam logic [STATE_W-1:0] c_PCUPD2 = STATE_W'(8);
    localparam logic [STATE_W-1:0] c_BR1    = STATE_W'(9);
    localparam logic [STATE_W-1:0] c_BRT    = STATE_W'(10);
    localparam logic [STATE_W-1:0] c_ANN1   = STATE_W'(11);
    localparam logic [STATE_W-1:0] c_ANN2   = STATE_W'(12);
    localparam logic [STATE_W-1:0] c_TRAP   = STATE_W'(13);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_next_state;
    logic               w_timeout;
    logic               w_unused_ir;

    // Condition bits are evaluated outside and arrive on COND; displacement feeds the datapath directly.
    assign w_unused_ir = ^{ctl.IR[28:25], ctl.IR[21:0]};

`ifdef MFC_TIMEOUT_EN
    localparam logic [3:0] c_TIMEOUT = 4'(MFC_TIMEOUT);
    logic [3:0] r_wait_cnt;

    // Zero in the first FETCH2 cycle, so it holds the number of FETCH2 cycles already spent.
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            r_wait_cnt <= 4'd0;
        end else if (r_state != c_FETCH2) begin
            r_wait_cnt <= 4'd0;
        end else begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
        end
    end

    assign w_timeout = ((r_wait_cnt + 4'd1) == c_TIMEOUT);
`else
    logic w_unused_cfg;
    assign w_unused_cfg = (MFC_TIMEOUT == 0);
    assign w_timeout    = 1'b0;
`endif

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            r_state <= c_RST0;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = c_RST0;
        case (r_state)
            c_RST0:   w_next_state = c_RST1;
            c_RST1:   w_next_state = c_FETCH1;
            c_FETCH1: w_next_state = c_FETCH2;
            c_FETCH2: begin
                // MFC wins over a timeout reached on the same edge.
                if (ctl.MFC)        w_next_state = c_FETCH3;
                else if (w_timeout) w_next_state = c_TRAP;
                else                w_next_state = c_FETCH2;
            end
            c_FETCH3: w_next_state = c_DECODE;
            c_DECODE: begin
                if (ctl.IR[31:30] == 2'b10)                                w_next_state = c_ALU1;
                else if (ctl.IR[31:30] == 2'b00 && ctl.IR[24:22] == 3'b010) w_next_state = c_BR1;
                else                                                       w_next_state = c_PCUPD1;
            end
            c_ALU1:   w_next_state = c_PCUPD1;
            c_PCUPD1: w_next_state = c_PCUPD2;
            c_PCUPD2: w_next_state = c_FETCH1;
            c_BR1: begin
                if (ctl.COND)       w_next_state = c_BRT;
                else if (ctl.IR[29]) w_next_state = c_ANN1;
                else                w_next_state = c_PCUPD2;
            end
            c_BRT:    w_next_state = c_FETCH1;
            c_ANN1:   w_next_state = c_ANN2;
            c_ANN2:   w_next_state = c_PCUPD2;
            c_TRAP:   w_next_state = c_RST0;
            default:  w_next_state = c_RST0;
        endcase
    end

    // Pure decode of the state register so an asynchronous Clr idles every enable at once.
    always_comb begin
        ctl.IRE      = 1'b1;
        ctl.MDRE     = 1'b1;
        ctl.MARE     = 1'b1;
        ctl.PCE      = 1'b1;
        ctl.nPCE     = 1'b1;
        ctl.RFE      = 1'b1;
        ctl.ClrPC    = 1'b1;
        ctl.nPCClr   = 1'b1;
        ctl.IRClr    = 1'b1;
        ctl.MFA      = 1'b0;
        ctl.ALUE     = 1'b0;
        ctl.nPC_ADD  = 1'b0;
        ctl.BAUX     = 1'b0;
        ctl.ALU_SEL  = 1'b0;
        ctl.AOP_SEL  = 1'b0;
        ctl.DISP_SEL = 1'b0;
        ctl.nPC_SEL  = 2'd0;
        ctl.MAR_SEL  = 2'd0;
        ctl.MDR_SEL  = 2'd0;
        ctl.CIN_SEL  = 2'd0;
        ctl.RC_SEL   = 2'd0;
        ctl.TRAP_REQ = 1'b0;
        case (r_state)
            c_RST0: begin
                ctl.ClrPC  = 1'b0;
                ctl.nPCClr = 1'b0;
                ctl.IRClr  = 1'b0;
            end
            c_RST1, c_PCUPD2, c_ANN1: begin
                ctl.nPCE    = 1'b0;
                ctl.nPC_ADD = 1'b1;
            end
            c_FETCH1: ctl.MARE = 1'b0;
            c_FETCH2: begin
                ctl.MFA  = 1'b1;
                ctl.MDRE = 1'b0;
            end
            c_FETCH3: ctl.IRE = 1'b0;
            c_ALU1: begin
                ctl.CIN_SEL = 2'd2;
                ctl.RFE     = 1'b0;
                ctl.ALUE    = 1'b1;
            end
            c_PCUPD1, c_BR1, c_ANN2: ctl.PCE = 1'b0;
            c_BRT: begin
                ctl.nPC_SEL = 2'd2;
                ctl.BAUX    = 1'b1;
                ctl.nPCE    = 1'b0;
            end
`ifdef MFC_TIMEOUT_EN
            c_TRAP: ctl.TRAP_REQ = 1'b1;
`endif
            default: ;
        endcase
    end

    assign ctl.STATE = r_state;

endmodule
`default_nettype wire

// File: tb/tb_dp_control_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_dp_control_sequencer                                         |
// | Brief    : Randomized bench with a cycle-trace model and a PC/nPC model.   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_dp_control_sequencer;

    typedef struct packed {
        logic IRE, MDRE, MARE, PCE, nPCE, RFE, ClrPC, nPCClr, IRClr;
        logic MFA, ALUE, nPC_ADD, BAUX, ALU_SEL, AOP_SEL, DISP_SEL;
        logic [1:0] nPC_SEL, MAR_SEL, MDR_SEL, CIN_SEL, RC_SEL;
        logic TRAP_REQ;
    } ovec_t;

    typedef struct {
        ovec_t       exp;
        int          step;
        logic [31:0] ir;
        logic        mfc, cond;
        bit          chk;
        logic [31:0] epc, enpc;
    } cyc_t;

    localparam int S_RST0 = 0, S_RST1 = 1, S_F1 = 2, S_F2 = 3, S_F3 = 4, S_DEC = 5;
    localparam int S_ALU1 = 6, S_PCU1 = 7, S_PCU2 = 8, S_BR1 = 9, S_BRT = 10;
    localparam int S_ANN1 = 11, S_ANN2 = 12;

    logic Clk = 1'b0;
    logic Clr = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;

    cyc_t        q[$];
    logic [31:0] arch_pc, arch_npc;
    logic [31:0] dp_pc, dp_npc, dp_mar;

    dp_control_sequencer_if #(.STATE_W(5)) ctl ();

    dp_control_sequencer #(.MFC_TIMEOUT(15), .STATE_W(5)) dut (
        .Clk (Clk),
        .Clr (Clr),
        .ctl (ctl)
    );

    always #5 Clk = ~Clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Minimal PC/nPC/MAR datapath driven by the sequencer's controls.
    always @(posedge Clk) begin
        if (!ctl.ClrPC)     dp_pc <= 32'd0;
        else if (!ctl.PCE)  dp_pc <= dp_npc;
        if (!ctl.nPCClr) dp_npc <= 32'd0;
        else if (!ctl.nPCE) begin
            if (ctl.nPC_SEL == 2'd2) dp_npc <= dp_mar + {{8{ctl.IR[21]}}, ctl.IR[21:0], 2'b00};
            else if (ctl.nPC_ADD)    dp_npc <= dp_npc + 32'd4;
        end
        if (!ctl.MARE) dp_mar <= dp_pc;
    end

    function automatic ovec_t step_vec(int s);
        ovec_t v;
        v = '0;
        {v.IRE, v.MDRE, v.MARE, v.PCE, v.nPCE, v.RFE, v.ClrPC, v.nPCClr, v.IRClr} = 9'h1FF;
        case (s)
            S_RST0: {v.ClrPC, v.nPCClr, v.IRClr} = 3'b000;
            S_RST1, S_PCU2, S_ANN1: begin v.nPCE = 1'b0; v.nPC_ADD = 1'b1; end
            S_F1:   v.MARE = 1'b0;
            S_F2:   begin v.MFA = 1'b1; v.MDRE = 1'b0; end
            S_F3:   v.IRE = 1'b0;
            S_ALU1: begin v.CIN_SEL = 2'd2; v.RFE = 1'b0; v.ALUE = 1'b1; end
            S_PCU1, S_BR1, S_ANN2: v.PCE = 1'b0;
            S_BRT:  begin v.nPC_SEL = 2'd2; v.BAUX = 1'b1; v.nPCE = 1'b0; end
            default: ;
        endcase
        return v;
    endfunction

    function automatic ovec_t dut_vec();
        return {ctl.IRE, ctl.MDRE, ctl.MARE, ctl.PCE, ctl.nPCE, ctl.RFE, ctl.ClrPC, ctl.nPCClr,
                ctl.IRClr, ctl.MFA, ctl.ALUE, ctl.nPC_ADD, ctl.BAUX, ctl.ALU_SEL, ctl.AOP_SEL,
                ctl.DISP_SEL, ctl.nPC_SEL, ctl.MAR_SEL, ctl.MDR_SEL, ctl.CIN_SEL, ctl.RC_SEL,
                ctl.TRAP_REQ};
    endfunction

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    task automatic check_vec(string name, int step, ovec_t exp);
        ovec_t act;
        act = dut_vec();
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step=%0d t=%0t: outputs got %h expected %h", name, step, $time, act, exp);
        end
    endtask

    task automatic check_int(string name, longint act, longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic push(int step, logic [31:0] ir, logic mfc, logic cond, bit chk);
        cyc_t c;
        c.exp = step_vec(step); c.step = step; c.ir = ir; c.mfc = mfc; c.cond = cond;
        c.chk = chk; c.epc = arch_pc; c.enpc = arch_npc;
        q.push_back(c);
    endtask

    task automatic gen_reset();
        arch_pc  = 32'd0;
        arch_npc = 32'd4;
        push(S_RST0, $urandom, rb(), rb(), 1'b0);
        push(S_RST1, $urandom, rb(), rb(), 1'b1);
    endtask

    // Architectural effect of one instruction on PC/nPC, plus its expected control trace.
    task automatic gen_instr(logic [31:0] ir, int d, logic cond);
        logic [31:0] tgt;
        push(S_F1, ir, rb(), rb(), 1'b0);
        for (int i = 0; i < d; i++) push(S_F2, ir, 1'b0, rb(), 1'b0);
        push(S_F2, ir, 1'b1, rb(), 1'b0);
        push(S_F3, ir, rb(), rb(), 1'b0);
        push(S_DEC, ir, rb(), rb(), 1'b0);
        if (ir[31:30] == 2'b10) begin
            push(S_ALU1, ir, rb(), rb(), 1'b0);
            push(S_PCU1, ir, rb(), rb(), 1'b0);
            arch_pc = arch_npc; arch_npc = arch_npc + 32'd4;
            push(S_PCU2, ir, rb(), rb(), 1'b1);
        end else if (ir[31:30] == 2'b00 && ir[24:22] == 3'b010) begin
            push(S_BR1, ir, rb(), cond, 1'b0);
            if (cond) begin
                tgt = arch_pc + {{8{ir[21]}}, ir[21:0], 2'b00};
                arch_pc = arch_npc; arch_npc = tgt;
                push(S_BRT, ir, rb(), rb(), 1'b1);
            end else if (ir[29]) begin
                push(S_ANN1, ir, rb(), rb(), 1'b0);
                push(S_ANN2, ir, rb(), rb(), 1'b0);
                arch_pc = arch_npc + 32'd4; arch_npc = arch_npc + 32'd8;
                push(S_PCU2, ir, rb(), rb(), 1'b1);
            end else begin
                arch_pc = arch_npc; arch_npc = arch_npc + 32'd4;
                push(S_PCU2, ir, rb(), rb(), 1'b1);
            end
        end else begin
            push(S_PCU1, ir, rb(), rb(), 1'b0);
            arch_pc = arch_npc; arch_npc = arch_npc + 32'd4;
            push(S_PCU2, ir, rb(), rb(), 1'b1);
        end
    endtask

    // Entered and left just after a rising edge.
    task automatic run_queue();
        cyc_t c;
        while (q.size() > 0) begin
            c = q.pop_front();
            ctl.IR = c.ir; ctl.MFC = c.mfc; ctl.COND = c.cond;
            @(negedge Clk);
            check_vec("trace", c.step, c.exp);
            @(posedge Clk); #1;
            if (c.chk) begin
                check_int("pc", dp_pc, c.epc);
                check_int("npc", dp_npc, c.enpc);
            end
        end
    endtask

    task automatic do_reset();
        Clr = 1'b0;
        #1;
        check_vec("reset_async", S_RST0, step_vec(S_RST0));
        @(posedge Clk); #1;
        @(posedge Clk);
        @(negedge Clk);
        check_vec("reset_hold", S_RST0, step_vec(S_RST0));
        @(posedge Clk); #1;
        Clr = 1'b1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r, ir;
        r = $urandom;
        case ($urandom_range(0, 2))
            0: ir = {2'b10, r[29:0]};
            1: ir = {2'b00, r[29], r[28:25], 3'b010, {8{r[13]}}, r[13:0]};
            default: begin
                ir = r;
                ir[31:30] = r[31] ? 2'b11 : 2'b01;
                if (r[30]) begin ir[31:30] = 2'b00; ir[24:22] = 3'b100; end
            end
        endcase
        return ir;
    endfunction

    initial begin
        int n0, mfa_cnt, k;
        ctl.IR = 32'd0; ctl.MFC = 1'b0; ctl.COND = 1'b0;
        @(posedge Clk); #1;

        // Program A: ALU op then a taken branch.
        do_reset();
        gen_reset();
        n0 = q.size();
        gen_instr(32'hA2044012, 1, 1'b0);
        check_int("model_alu_cycles", q.size() - n0, 8);
        check_int("model_alu_pc", arch_pc, 32'h4);
        check_int("model_alu_npc", arch_npc, 32'h8);
        gen_instr(32'h3C800005, 0, 1'b1);
        check_int("model_taken_pc", arch_pc, 32'h8);
        check_int("model_taken_npc", arch_npc, 32'h18);
        run_queue();

        // Clr mid-fetch: MFA must drop with no clock edge.
        ctl.MFC = 1'b0;
        @(posedge Clk); #1;
        check_int("mfa_in_fetch2", ctl.MFA, 1);
        do_reset();

        // Program B: ALU, annulled untaken branch on slow memory, then random traffic.
        gen_reset();
        gen_instr(32'hA2044012, 1, 1'b0);
        n0 = q.size();
        gen_instr(32'h3C800005, 3, 1'b0);
        mfa_cnt = 0;
        for (int i = n0; i < q.size(); i++) mfa_cnt += int'(q[i].exp.MFA);
        check_int("model_slow_mfa_cycles", mfa_cnt, 4);
        check_int("model_annul_pc", arch_pc, 32'hC);
        check_int("model_annul_npc", arch_npc, 32'h10);
        for (int i = 0; i < 40; i++) gen_instr(rand_instr(), $urandom_range(0, 6), rb());
        run_queue();

`ifdef MFC_TIMEOUT_EN
        do_reset();
        gen_reset();
        push(S_F1, 32'd0, 1'b0, 1'b0, 1'b0);
        run_queue();
        ctl.MFC = 1'b0;
        k = 0;
        while (k < 40 && ctl.TRAP_REQ !== 1'b1) begin
            @(posedge Clk); #1;
            k++;
        end
        check_int("trap_latency", k, 15);
        @(posedge Clk); #1;
        check_vec("after_trap", S_RST0, step_vec(S_RST0));
`else
        k = 0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
